// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the multicycle add/subtract block.
package addsub_pkg;

    // Controller states: waiting for a request, stepping through slices,
    // and holding the finished result for the consumer.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices making up a WIDTH-bit operand.
    function automatic int unsigned num_chunks(input int unsigned width,
                                               input int unsigned chunk);
        if (chunk == 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

    // Width of the slice index register; never narrower than one bit so
    // the single-slice configuration still has a legal register.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n > 1) begin
            return $clog2(n);
        end
        return 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational ripple-carry adder for one CHUNK-bit slice.
// Cmsb is the carry into the slice MSB, used for signed overflow on the
// most significant slice.
module addsub_chunk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         Cmsb
);

    // Bit-serial ripple through the slice.
    always_comb begin
        logic [W:0] c;
        c    = '0;
        S    = '0;
        c[0] = Cin;
        for (int unsigned i = 0; i < W; i++) begin
            S[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        Cout = c[W];
        Cmsb = c[W-1];
    end

endmodule

// File: rtl/addsub_multicycle.sv
// Multicycle two's-complement adder/subtractor with optional saturation.
// One CHUNK-bit slice is summed per clock, LSB slice first, through a single
// shared slice adder; the result is held with valid/ready until consumed.
module addsub_multicycle
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Zero,
    output logic             Neg
);

    localparam int unsigned N    = num_chunks(WIDTH, CHUNK);
    localparam int unsigned IDXW = idx_width(N);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    // Refuse to build a configuration whose slices do not tile the word.
    if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("addsub_multicycle: WIDTH must be a nonzero multiple of CHUNK");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;       // B already inverted for subtraction
    logic              sat_q;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  res_q;
    logic              ovfl_q;
    logic              zero_q;
    logic              neg_q;

    // ------------------------------------------------------------------
    // Combinational datapath signals
    // ------------------------------------------------------------------
    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK-1:0]  s_sl;
    logic              c_out;
    logic              c_msb;
    logic [WIDTH-1:0]  res_wr;
    logic              last_slice;
    logic              accept;
    logic              ovfl_raw;
    logic [WIDTH-1:0]  sat_word;
    logic [WIDTH-1:0]  final_word;

    assign accept     = in_valid && in_ready;
    assign last_slice = (idx_q == LAST_IDX);

    // Select the operand slices addressed by the chunk index.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    addsub_chunk #(
        .W (CHUNK)
    ) u_chunk (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry_q),
        .S    (s_sl),
        .Cout (c_out),
        .Cmsb (c_msb)
    );

    // Merge the freshly computed slice into the partial result word.
    always_comb begin
        res_wr = res_q;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                res_wr[i*CHUNK +: CHUNK] = s_sl;
            end
        end
    end

    // Overflow and saturation only matter on the final (most significant)
    // slice; the saturation direction follows the sign of the captured A.
    always_comb begin
        ovfl_raw   = c_msb ^ c_out;
        sat_word   = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        final_word = (sat_q && ovfl_raw) ? sat_word : res_wr;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register with asynchronous abort to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: requests seen outside IDLE are simply not accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)     state_d = ST_CALC;
            ST_CALC: if (last_slice) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: in_ready  = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Capture operands on accept, step one slice per CALC edge, and commit
    // the final (possibly saturated) word and flags on the last slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sat_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            ovfl_q  <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= A;
                        b_q     <= sub ? ~B : B;
                        sat_q   <= sat;
                        carry_q <= sub;
                        idx_q   <= '0;
                        ovfl_q  <= 1'b0;
                        zero_q  <= 1'b0;
                        neg_q   <= 1'b0;
                    end
                end
                ST_CALC: begin
                    carry_q <= c_out;
                    if (last_slice) begin
                        idx_q  <= '0;
                        res_q  <= final_word;
                        ovfl_q <= ovfl_raw;
                        zero_q <= (final_word == '0);
                        neg_q  <= final_word[WIDTH-1];
                    end else begin
                        idx_q  <= idx_q + IDXW'(1);
                        res_q  <= res_wr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Sum  = res_q;
    assign Ovfl = ovfl_q;
    assign Zero = zero_q;
    assign Neg  = neg_q;

endmodule

// File: doc/addsub_multicycle.md
ADDSUB_MULTICYCLE -- requirements
Module: addsub_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per cycle; WIDTH mod CHUNK SHALL be 0, and a violation SHALL be a elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit, indicating the operand request is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, indicating the block can accept a request.
REQ-007 The block SHALL have port A, input, WIDTH bits, the first operand (two's complement).
REQ-008 The block SHALL have port B, input, WIDTH bits, the second operand (two's complement).
REQ-009 The block SHALL have port sub, input, 1 bit: 1 computes A-B, 0 computes A+B.
REQ-010 The block SHALL have port sat, input, 1 bit: 1 selects a saturating result on overflow.
REQ-011 The block SHALL have port out_valid, output, 1 bit, indicating the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, indicating the consumer accepts the result.
REQ-013 The block SHALL have port Sum, output, WIDTH bits, the result.
REQ-014 The block SHALL have port Ovfl, output, 1 bit, the raw signed overflow.
REQ-015 The block SHALL have port Zero, output, 1 bit, set when Sum == 0.
REQ-016 The block SHALL have port Neg, output, 1 bit, equal to Sum[WIDTH-1].

Function
REQ-017 The FSM SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-018 Acceptance SHALL occur at a rising edge where in_valid && in_ready; at that edge A, ~B-or-B, sub and sat are registered, the carry register is loaded with sub, the chunk index is cleared, and the state becomes CALC.
REQ-019 In CALC, each edge SHALL add one CHUNK slice (LSB slice first) with the registered carry, write the slice into the result register, and update the carry.
REQ-020 Let N = WIDTH/CHUNK; after the Nth CALC edge, the state SHALL be DONE, so out_valid rises exactly N edges after acceptance.
REQ-021 Ovfl SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1, evaluated on the final slice.
REQ-022 When sat=1 and Ovfl=1, Sum SHALL be 2^(WIDTH-1)-1 if the registered A[WIDTH-1]=0, else -2^(WIDTH-1); otherwise Sum SHALL be the wrapped modulo-2^WIDTH result.
REQ-023 Zero and Neg SHALL be derived from the final (possibly saturated) Sum, while Ovfl SHALL report the raw overflow regardless of sat.
REQ-024 In DONE, Sum and the flags SHALL hold stable until out_valid && out_ready, and at that edge the state SHALL return to IDLE.
REQ-025 Changes on A, B, sub and sat outside the accept edge SHALL have no effect, and in_valid seen in CALC or DONE SHALL be ignored, not queued.
REQ-026 When N=1 (CHUNK == WIDTH), the latency SHALL be 1 edge and the same FSM SHALL apply.

Reset
REQ-027 Asserting rst at any time, including mid-CALC or in DONE, SHALL immediately force the state to IDLE and abort the operation.
REQ-028 During reset, in_ready SHALL be 1, out_valid SHALL be 0, and Sum, Ovfl, Zero, Neg, carry and index SHALL be 0.
REQ-029 After rst deasserts, the first acceptance SHALL be possible at the next rising edge.

Structure
REQ-030 A package addsub_pkg SHALL hold the FSM state enum and a function computing N and the index width, $clog2(N) with a minimum of 1.
REQ-031 A combinational sub-module addsub_chunk SHALL implement the CHUNK-bit ripple adder with Cin, S, Cout and carry-into-MSB outputs, and SHALL be instantiated once and muxed by the index.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-032 Stimulus A=0x7FFF, B=0x0001, sub=0, sat=0 SHALL give Sum=0x8000, Ovfl=1, Neg=1, Zero=0, with out_valid 4 edges after acceptance; the same operands with sat=1 SHALL give Sum=0x7FFF, Ovfl=1, Neg=0.
REQ-033 Stimulus A=0x8000, B=0x0001, sub=1, sat=1 SHALL give Sum=0x8000, Ovfl=1; with A=0x1234, B=0x1234, sub=1 it SHALL give Sum=0x0000, Zero=1, Ovfl=0.
REQ-034 With out_ready held 0 for 6 cycles in DONE, Sum and the flags SHALL stay constant and in_ready SHALL be 0; at the out_ready=1 edge the state SHALL go to IDLE, with in_ready=1 the next cycle.
REQ-035 Asserting rst asynchronously after the second CALC edge SHALL give out_valid=0 and in_ready=1 without waiting for a clock, and a new request 0x0003+0x0004 SHALL then yield 0x0007.
REQ-036 Toggling A and B every cycle during CALC SHALL leave the result equal to the operands captured at acceptance.
REQ-037 With WIDTH=8 and CHUNK=8, A=0x80, B=0x80, sub=0, sat=0 SHALL give Sum=0x00, Ovfl=1, Zero=1 at 1-edge latency.
